// File: rtl/hack_uart_rom_loader_if.sv
// Instruction-ROM write port driven by the UART loader: one write per clock when we is high.
interface hack_uart_rom_loader_if #(
    parameter int ADDR_W = 15
);
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;

    modport master (output rom_we, rom_addr, rom_data);
    modport slave  (input  rom_we, rom_addr, rom_data);
endinterface

// File: rtl/hack_uart_rom_loader.sv
// UART bootloader for the Hack computer: 'H', 16-bit big-endian word count, then big-endian words.
// Keeps the CPU in reset while the image streams into instruction ROM.
module hack_uart_rom_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 15,
    parameter int TIMEOUT_CLKS = 5_000_000
) (
    input  logic                   i_CLK,
    input  logic                   i_RESET_n,
    input  logic                   i_UART_RX,
    hack_uart_rom_loader_if.master rom,
    output logic                   o_CPU_RESET_n,
    output logic                   o_BUSY,
    output logic                   o_DONE,
    output logic                   o_ERROR
);

    localparam int                    BIT_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [BIT_CNT_W-1:0] HALF_BIT  = BIT_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_CNT_W-1:0] FULL_BIT  = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam int                    TO_W      = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [ADDR_W:0]       MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [7:0]            HEADER    = 8'h48;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_DONE, S_ERROR
    } state_t;

    logic [1:0]           rx_sync;
    logic                 rx_prev;
    rx_state_t            rx_state;
    logic [BIT_CNT_W-1:0] rx_cnt;
    logic [2:0]           rx_bit;
    logic [7:0]           rx_byte;
    logic                 rx_valid;
    logic                 rx_frame_err;

    // NOTE: every register here uses <= so all flops update from the same pre-edge values.
    always_ff @(posedge i_CLK) begin
        if (!i_RESET_n) begin
            rx_sync      <= 2'b11;
            rx_prev      <= 1'b1;
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_sync      <= {rx_sync[0], i_UART_RX};
            rx_prev      <= rx_sync[1];
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_sync[1]) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_BIT) begin
                        // A glitch shorter than half a bit is not a start bit.
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == FULL_BIT) begin
                        rx_cnt  <= '0;
                        rx_byte <= {rx_sync[1], rx_byte[7:1]};
                        rx_bit  <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == FULL_BIT) begin
                        rx_cnt       <= '0;
                        rx_valid     <= rx_sync[1];
                        rx_frame_err <= !rx_sync[1];
                        rx_state     <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    state_t          state;
    logic [7:0]      hi_byte;
    logic [15:0]     len;
    logic [ADDR_W:0] index;
    logic [ADDR_W:0] index_nxt;
    logic [TO_W-1:0] idle_cnt;
    logic [15:0]     rx_word;

    assign index_nxt = index + 1'b1;
    assign rx_word   = {hi_byte, rx_byte};

    always_ff @(posedge i_CLK) begin
        if (!i_RESET_n) begin
            state         <= S_IDLE;
            hi_byte       <= '0;
            len           <= '0;
            index         <= '0;
            idle_cnt      <= '0;
            rom.rom_we    <= 1'b0;
            rom.rom_addr  <= '0;
            rom.rom_data  <= '0;
            o_CPU_RESET_n <= 1'b0;
            o_BUSY        <= 1'b0;
            o_DONE        <= 1'b0;
            o_ERROR       <= 1'b0;
        end else begin
            rom.rom_we <= 1'b0;
            idle_cnt   <= (rx_valid || !o_BUSY) ? '0 : idle_cnt + 1'b1;

            // Abort is checked first so an expiring timeout beats a byte landing that clock.
            if (o_BUSY && (idle_cnt == TO_LAST || rx_frame_err)) begin
                state         <= S_ERROR;
                o_BUSY        <= 1'b0;
                o_ERROR       <= 1'b1;
                o_CPU_RESET_n <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (rx_valid && rx_byte == HEADER) begin
                            state         <= S_LEN_HI;
                            o_BUSY        <= 1'b1;
                            o_CPU_RESET_n <= 1'b0;
                            o_DONE        <= 1'b0;
                            o_ERROR       <= 1'b0;
                        end else if (state == S_IDLE) begin
                            o_CPU_RESET_n <= 1'b1;
                        end
                    end
                    S_LEN_HI: begin
                        if (rx_valid) begin
                            hi_byte <= rx_byte;
                            state   <= S_LEN_LO;
                        end
                    end
                    S_LEN_LO: begin
                        if (rx_valid) begin
                            len   <= rx_word;
                            index <= '0;
                            if (rx_word == 16'd0) begin
                                state         <= S_DONE;
                                o_BUSY        <= 1'b0;
                                o_DONE        <= 1'b1;
                                o_CPU_RESET_n <= 1'b1;
                            end else if (32'(rx_word) > 32'(MAX_WORDS)) begin
                                state   <= S_ERROR;
                                o_BUSY  <= 1'b0;
                                o_ERROR <= 1'b1;
                            end else begin
                                state <= S_DATA_HI;
                            end
                        end
                    end
                    S_DATA_HI: begin
                        if (rx_valid) begin
                            hi_byte <= rx_byte;
                            state   <= S_DATA_LO;
                        end
                    end
                    S_DATA_LO: begin
                        if (rx_valid) begin
                            rom.rom_we   <= 1'b1;
                            rom.rom_addr <= index[ADDR_W-1:0];
                            rom.rom_data <= rx_word;
                            index        <= index_nxt;
                            if (32'(index_nxt) == 32'(len)) begin
                                state         <= S_DONE;
                                o_BUSY        <= 1'b0;
                                o_DONE        <= 1'b1;
                                o_CPU_RESET_n <= 1'b1;
                            end else begin
                                state <= S_DATA_HI;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hack_uart_rom_loader.sv
// Scoreboard bench for hack_uart_rom_loader: stimulus pushes expected ROM writes, a monitor pops them.
module tb_hack_uart_rom_loader;

    localparam int CPB = 8;
    localparam int AW  = 4;
    localparam int TO  = 300;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    logic r_CLK = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic cpu_rst_n, busy, done, error;

    hack_uart_rom_loader_if #(.ADDR_W(AW)) rom ();

    hack_uart_rom_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .i_CLK        (r_CLK),
        .i_RESET_n    (rst_n),
        .i_UART_RX    (rx),
        .rom          (rom),
        .o_CPU_RESET_n(cpu_rst_n),
        .o_BUSY       (busy),
        .o_DONE       (done),
        .o_ERROR      (error)
    );

    always #5 r_CLK = ~r_CLK;

    int          n_checks = 0;
    int          n_pass   = 0;
    wr_t         sb[$];
    logic [15:0] tx_words[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge r_CLK) begin : monitor
        wr_t exp_wr;
        if (rst_n === 1'b1 && rom.rom_we === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL rom_write: got write addr 0x%0h data 0x%0h, expected no write",
                         rom.rom_addr, rom.rom_data);
            end else begin
                exp_wr = sb.pop_front();
                check("rom_addr", 32'(rom.rom_addr), 32'(exp_wr.addr));
                check("rom_data", 32'(rom.rom_data), 32'(exp_wr.data));
            end
        end
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge r_CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop = 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(good_stop);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    // Sends a load with the words queued in tx_words; words the loader should accept are expected writes.
    task automatic send_load(input logic [15:0] n);
        send_byte(8'h48);
        check("busy_after_header", 32'(busy), 32'd1);
        check("cpu_held_after_header", 32'(cpu_rst_n), 32'd0);
        check("done_cleared_by_header", 32'(done), 32'd0);
        check("error_cleared_by_header", 32'(error), 32'd0);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        for (int i = 0; i < tx_words.size(); i++) begin
            if (i < int'(n) && int'(n) <= (1 << AW)) sb.push_back({AW'(i), tx_words[i]});
            send_byte(tx_words[i][15:8]);
            send_byte(tx_words[i][7:0]);
        end
    endtask

    task automatic check_status(input string tag, input logic exp_busy, input logic exp_done,
                                input logic exp_err, input logic exp_cpu);
        check({tag, "_busy"},  32'(busy),      32'(exp_busy));
        check({tag, "_done"},  32'(done),      32'(exp_done));
        check({tag, "_error"}, 32'(error),     32'(exp_err));
        check({tag, "_cpu"},   32'(cpu_rst_n), 32'(exp_cpu));
    endtask

    // Outcome of a load from its declared length and the number of words actually delivered.
    function automatic bit load_ok(input int n, input int sent);
        return n <= (1 << AW) && sent >= n;
    endfunction

    initial begin : watchdog
        #600_000;
        $display("FAIL watchdog: got no finish within 60000 cycles, expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        int  n;
        int  sent;
        bit  ok;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (10) @(negedge r_CLK);
        check("reset_cpu", 32'(cpu_rst_n), 32'd0);
        check("reset_we",  32'(rom.rom_we), 32'd0);
        check("reset_addr", 32'(rom.rom_addr), 32'd0);
        check("reset_data", 32'(rom.rom_data), 32'd0);
        check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge r_CLK);
        check("cpu_released", 32'(cpu_rst_n), 32'd1);

        tx_words = '{16'h1234, 16'hABCD};
        send_load(16'd2);
        check_status("two_words", 1'b0, 1'b1, 1'b0, 1'b1);

        send_byte(8'h55);
        send_byte(8'h00);
        check_status("ignored_bytes", 1'b0, 1'b1, 1'b0, 1'b1);
        tx_words.delete();
        send_load(16'd0);
        check_status("empty_image", 1'b0, 1'b1, 1'b0, 1'b1);

        tx_words = '{16'h1122};
        send_load(16'd3);
        repeat (TO + 50) @(negedge r_CLK);
        check_status("timeout", 1'b0, 1'b0, 1'b1, 1'b0);

        tx_words = '{16'h0A0B};
        send_load(16'd2);
        send_byte(8'h5A, 1'b0);
        check_status("frame_error", 1'b0, 1'b0, 1'b1, 1'b0);
        tx_words = '{16'hBEEF};
        send_load(16'd1);
        check_status("recover", 1'b0, 1'b1, 1'b0, 1'b1);

        tx_words = '{16'($urandom), 16'($urandom)};
        send_load(16'd4);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge r_CLK);
        rst_n = 1'b0;
        repeat (3) @(negedge r_CLK);
        check("midload_reset_we", 32'(rom.rom_we), 32'd0);
        check_status("midload_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rx    = 1'b1;
        rst_n = 1'b1;
        @(negedge r_CLK);
        check("midload_cpu_released", 32'(cpu_rst_n), 32'd1);
        repeat (2 * CPB) @(negedge r_CLK);

        tx_words.delete();
        for (int i = 0; i < (1 << AW); i++) tx_words.push_back(16'($urandom));
        send_load(16'(1 << AW));
        check_status("full_rom", 1'b0, 1'b1, 1'b0, 1'b1);

        tx_words.delete();
        send_load(16'((1 << AW) + 1));
        check_status("oversize", 1'b0, 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(1, 0) == 1) send_byte(8'($urandom_range(8'h47, 8'h00)));
            if ($urandom_range(4, 0) == 0) begin
                n    = $urandom_range(65535, (1 << AW) + 1);
                sent = 0;
            end else begin
                n    = $urandom_range(5, 1);
                sent = ($urandom_range(3, 0) == 0) ? $urandom_range(n - 1, 0) : n;
            end
            tx_words.delete();
            for (int i = 0; i < sent; i++) tx_words.push_back(16'($urandom));
            send_load(16'(n));
            ok = load_ok(n, sent);
            if (!ok) repeat (TO + 50) @(negedge r_CLK);
            check_status("random_load", 1'b0, ok, !ok, ok);
        end

        repeat (20) @(negedge r_CLK);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
